// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: drains the draw queue each frame and turns each entry into scaled, clipped framebuffer writes.
// Ports: sys_clock/reset (async high); frame_start starts a drain; is_empty + sprite_* are the show-ahead queue head,
// dequeue pops it; sprite_r_en/sprite_r_addr/sprite_r_data form the 1-cycle-latency sprite read port;
// fb_w_en/fb_w_addr/fb_w_data drive framebuffer writes; busy is high outside IDLE; frame_done pulses when the queue is empty.
module sprite_draw_scheduler #(
  parameter int SPRITE_ADDR_SIZE = 13,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int FB_ADDR_W = 17
) (
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        is_empty,
  input  logic [7:0]                  sprite_id,
  input  logic [15:0]                 sprite_x,
  input  logic [15:0]                 sprite_y,
  input  logic [7:0]                  sprite_scale,
  output logic                        dequeue,
  output logic                        sprite_r_en,
  output logic [SPRITE_ADDR_SIZE:0]   sprite_r_addr,
  input  logic [3:0]                  sprite_r_data,
  output logic                        fb_w_en,
  output logic [FB_ADDR_W-1:0]        fb_w_addr,
  output logic [3:0]                  fb_w_data,
  output logic                        busy,
  output logic                        frame_done
);
  typedef enum logic [1:0] {IDLE, CHECK, DRAW, FLUSH} state_t;
  localparam logic signed [17:0] SW = 18'(SCREEN_W);
  localparam logic signed [17:0] SH = 18'(SCREEN_H);
  state_t state_q, state_d;
  logic [3:0] id_q, id_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [7:0] scale_q, scale_d, sx_q, sx_d, sy_q, sy_d;
  logic [12:0] ox_q, ox_d, oy_q, oy_d;
  logic [4:0] px_q, px_d, py_q, py_d;
  logic cand_q, cand_d;
  logic [FB_ADDR_W-1:0] cand_addr_q, cand_addr_d, wr_addr_q, wr_addr_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic sx_end, sy_end, col_end, last, on;
  logic signed [17:0] dx, dy;
  logic unused;
  assign unused = ^sprite_id[7:4];
  // replication sub-counters stand in for ox/scale and oy/scale
  assign sx_end = sx_q == scale_q - 8'd1;
  assign sy_end = sy_q == scale_q - 8'd1;
  assign col_end = sx_end && px_q == 5'd31;
  assign last = col_end && sy_end && py_q == 5'd31;
  assign dx = $signed({{2{x_q[15]}}, x_q}) + $signed({5'd0, ox_q});
  assign dy = $signed({{2{y_q[15]}}, y_q}) + $signed({5'd0, oy_q});
  assign on = !dx[17] && dx < SW && !dy[17] && dy < SH;
  always_ff @(posedge sys_clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = frame_start ? CHECK : IDLE;
      CHECK: state_d = is_empty ? IDLE : DRAW;
      DRAW:  state_d = last ? FLUSH : DRAW;
      FLUSH: state_d = CHECK;
    endcase
  end
  always_comb begin
    dequeue = state_q == CHECK && !is_empty;
    frame_done = state_q == CHECK && is_empty;
    busy = state_q != IDLE;
    sprite_r_en = state_q == DRAW;
    sprite_r_addr = sprite_r_en ? {id_q, py_q, px_q} : '0;
    // the write for a read lands while its data is on sprite_r_data; outputs hold between writes
    fb_w_en = cand_q && sprite_r_data != 4'd0;
    fb_w_addr = fb_w_en ? cand_addr_q : wr_addr_q;
    fb_w_data = fb_w_en ? sprite_r_data : wr_data_q;
  end
  always_comb begin
    id_d = dequeue ? sprite_id[3:0] : id_q;
    x_d = dequeue ? sprite_x : x_q;
    y_d = dequeue ? sprite_y : y_q;
    scale_d = dequeue ? (sprite_scale == 8'd0 ? 8'd1 : sprite_scale) : scale_q;
    sx_d = sx_q;
    sy_d = sy_q;
    px_d = px_q;
    py_d = py_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (dequeue) begin
      sx_d = '0;
      sy_d = '0;
      px_d = '0;
      py_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (sprite_r_en) begin
      sx_d = sx_end ? 8'd0 : sx_q + 8'd1;
      px_d = sx_end ? px_q + 5'd1 : px_q;
      ox_d = col_end ? 13'd0 : ox_q + 13'd1;
      sy_d = col_end ? (sy_end ? 8'd0 : sy_q + 8'd1) : sy_q;
      py_d = col_end && sy_end ? py_q + 5'd1 : py_q;
      oy_d = col_end ? oy_q + 13'd1 : oy_q;
    end
    cand_d = sprite_r_en && on;
    cand_addr_d = dy[FB_ADDR_W-1:0] * FB_ADDR_W'(SCREEN_W) + dx[FB_ADDR_W-1:0];
    wr_addr_d = fb_w_addr;
    wr_data_d = fb_w_data;
  end
  always_ff @(posedge sys_clock or posedge reset)
    if (reset) begin
      id_q <= '0;
      x_q <= '0;
      y_q <= '0;
      scale_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      px_q <= '0;
      py_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      cand_q <= 1'b0;
      cand_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      scale_q <= scale_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      px_q <= px_d;
      py_q <= py_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      cand_q <= cand_d;
      cand_addr_q <= cand_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed bench with a show-ahead queue and 1-cycle sprite memory model.
module tb_sprite_draw_scheduler;
  logic sys_clock = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic is_empty, dequeue, sprite_r_en, fb_w_en, busy, frame_done;
  logic [7:0] sprite_id, sprite_scale;
  logic [15:0] sprite_x, sprite_y;
  logic [13:0] sprite_r_addr;
  logic [3:0] sprite_r_data = 4'd0, fb_w_data;
  logic [16:0] fb_w_addr;
  logic [3:0] mem [16384];
  logic [7:0] q_id [16], q_sc [16];
  logic [15:0] q_x [16], q_y [16];
  int q_n = 0, q_h = 0, cyc = 0, t0 = 0, n_asrt = 0, n_fail = 0, saved_wr, saved_ren;
  int wr_cnt, deq_cnt, done_cnt, ren_cnt, first_wr_cyc, done_cyc, s2_hits;
  int deq_cyc [4];
  logic [16:0] first_addr, max_addr;
  logic [3:0] first_data;

  sprite_draw_scheduler dut (
    .sys_clock(sys_clock), .reset(reset), .frame_start(frame_start), .is_empty(is_empty),
    .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_scale(sprite_scale),
    .dequeue(dequeue), .sprite_r_en(sprite_r_en), .sprite_r_addr(sprite_r_addr),
    .sprite_r_data(sprite_r_data), .fb_w_en(fb_w_en), .fb_w_addr(fb_w_addr),
    .fb_w_data(fb_w_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 sys_clock = ~sys_clock;
  always @(posedge sys_clock) cyc <= cyc + 1;
  always @(posedge sys_clock) if (sprite_r_en) sprite_r_data <= mem[sprite_r_addr];
  always @(posedge sys_clock) if (dequeue) q_h <= q_h + 1;

  always_comb begin
    is_empty = q_h >= q_n;
    sprite_id = q_id[q_h[3:0]];
    sprite_x = q_x[q_h[3:0]];
    sprite_y = q_y[q_h[3:0]];
    sprite_scale = q_sc[q_h[3:0]];
  end

  always @(negedge sys_clock) begin
    if (fb_w_en) begin
      if (first_wr_cyc < 0) begin
        first_wr_cyc = cyc;
        first_addr = fb_w_addr;
        first_data = fb_w_data;
      end
      wr_cnt++;
      if (fb_w_addr > max_addr) max_addr = fb_w_addr;
      if ((fb_w_addr == 2 || fb_w_addr == 3 || fb_w_addr == 322 || fb_w_addr == 323) && fb_w_data == 4'd1) s2_hits++;
    end
    if (dequeue) begin
      if (deq_cnt < 4) deq_cyc[deq_cnt] = cyc;
      deq_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sprite_r_en) ren_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; deq_cnt = 0; done_cnt = 0; ren_cnt = 0; first_wr_cyc = -1; done_cyc = -1;
    s2_hits = 0; max_addr = '0; first_addr = '0; first_data = '0;
    for (int i = 0; i < 4; i++) deq_cyc[i] = -1;
  endtask

  task automatic push(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y, input logic [7:0] sc);
    q_id[q_n] = id; q_x[q_n] = x; q_y[q_n] = y; q_sc[q_n] = sc;
    q_n++;
  endtask

  task automatic start();
    @(posedge sys_clock); #1 frame_start = 1'b1; t0 = cyc;
    @(posedge sys_clock); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge sys_clock);
      n++;
    end
    #1 chk(tag, done_cnt > 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      logic [13:0] a;
      a = 14'(i);
      mem[i] = a[13:10] == 4'd2 ? a[3:0] : 4'd0;
    end
    for (int i = 0; i < 16; i++) begin
      q_id[i] = '0; q_x[i] = '0; q_y[i] = '0; q_sc[i] = '0;
    end
    clr();
    repeat (3) @(posedge sys_clock);
    #1 reset = 1'b0;
    chk("reset_outputs", {busy, dequeue, sprite_r_en, fb_w_en, frame_done, fb_w_addr, fb_w_data, sprite_r_addr}, 0);

    // unscaled: px 0 and 16 transparent, first visible pixel is px 1 one cycle after the first candidate
    clr(); push(8'd2, 16'd8, 16'd4, 8'd1); start();
    wait_done("unscaled_done_seen", 3000);
    chk("unscaled_writes", wr_cnt, 960);
    chk("unscaled_first_cyc", first_wr_cyc - t0, 4);
    chk("unscaled_first_addr", first_addr, 1289);
    chk("unscaled_first_data", first_data, 1);
    chk("unscaled_deq_cyc", deq_cyc[0] - t0, 1);
    chk("unscaled_deq_cnt", deq_cnt, 1);
    chk("unscaled_reads", ren_cnt, 1024);
    chk("unscaled_done_cyc", done_cyc - t0, 1027);
    chk("unscaled_busy_after", busy, 0);

    clr(); push(8'd2, 16'd0, 16'd0, 8'd2); start();
    wait_done("scale2_done_seen", 6000);
    chk("scale2_writes", wr_cnt, 3840);
    chk("scale2_px1_hits", s2_hits, 4);
    chk("scale2_reads", ren_cnt, 4096);
    chk("scale2_first_addr", first_addr, 2);
    chk("scale2_done_cyc", done_cyc - t0, 4099);

    clr(); push(8'd2, 16'hFFFC, 16'd230, 8'd1); start();
    wait_done("clip_done_seen", 3000);
    chk("clip_writes", wr_cnt, 270);
    chk("clip_max_addr_ok", max_addr < 17'd76800, 1);
    chk("clip_first_addr", first_addr, 73600);
    chk("clip_first_data", first_data, 4);
    chk("clip_reads", ren_cnt, 1024);

    clr(); push(8'd2, 16'd100, 16'd100, 8'd0); push(8'd2, 16'd100, 16'd50, 8'd1); push(8'd2, 16'd0, 16'd100, 8'd1);
    start();
    repeat (500) @(posedge sys_clock);
    #1 frame_start = 1'b1;
    @(posedge sys_clock); #1 frame_start = 1'b0;
    wait_done("drain_done_seen", 5000);
    chk("drain_deq0_cyc", deq_cyc[0] - t0, 1);
    chk("drain_gap01", deq_cyc[1] - deq_cyc[0], 1026);
    chk("drain_gap12", deq_cyc[2] - deq_cyc[1], 1026);
    chk("drain_reads", ren_cnt, 3072);
    chk("drain_done_cyc", done_cyc - t0, 3079);
    chk("drain_busy_after", busy, 0);
    repeat (5) @(posedge sys_clock);
    #1 chk("drain_done_cnt", done_cnt, 1);
    chk("drain_deq_cnt", deq_cnt, 3);
    chk("drain_queue_empty", is_empty, 1);

    clr(); push(8'd3, 16'd10, 16'd10, 8'd1); start();
    wait_done("blank_done_seen", 3000);
    chk("blank_writes", wr_cnt, 0);
    chk("blank_reads", ren_cnt, 1024);

    clr(); push(8'd2, 16'd8, 16'd4, 8'd1); start();
    repeat (100) @(posedge sys_clock);
    #1 reset = 1'b1;
    #1 chk("midreset_async", {busy, dequeue, sprite_r_en, fb_w_en, frame_done, fb_w_addr, fb_w_data, sprite_r_addr}, 0);
    saved_wr = wr_cnt; saved_ren = ren_cnt;
    @(negedge sys_clock);
    chk("midreset_edge", {busy, dequeue, sprite_r_en, fb_w_en, frame_done, fb_w_addr, fb_w_data, sprite_r_addr}, 0);
    repeat (2) @(posedge sys_clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge sys_clock);
    #1 chk("midreset_no_writes", wr_cnt, saved_wr);
    chk("midreset_no_reads", ren_cnt - saved_ren, 0);
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_idle", busy, 0);

    clr(); start();
    repeat (3) @(posedge sys_clock);
    #1 chk("empty_done_cnt", done_cnt, 1);
    chk("empty_done_cyc", done_cyc - t0, 1);
    chk("empty_no_deq", deq_cnt, 0);
    chk("empty_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
